// File: rtl/alu_iter_ctrl_pkg.sv
// Shared constants for the iterative MULTU/DIVU controller and the ALU decoder.
// Holds the ALU opcodes and the controller state encoding.
package alu_iter_ctrl_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_iter_ctrl_if.sv
// Request/result bundle between the main controller and the iterative unit.
// The main controller is master; alu_iter_ctrl is slave.
interface alu_iter_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op_div;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op_div, src_a, src_b,
        output mthi, mtlo, wdata,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op_div, src_a, src_b,
        input  mthi, mtlo, wdata,
        output busy, hi, lo
    );
endinterface

// File: rtl/alu_iter_ctrl.sv
// Multi-cycle MULTU/DIVU controller: one shift/add step per cycle on the
// shared ALU, owning the HI/LO pair.
module alu_iter_ctrl
    import alu_iter_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    alu_iter_ctrl_if.slave       bus,
    input  logic [WIDTH-1:0]     i_alu_result,
    output logic [WIDTH-1:0]     o_alu_src_a,
    output logic [WIDTH-1:0]     o_alu_src_b,
    output logic [2:0]           o_alu_control
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_m;

    logic [WIDTH-1:0] w_sum;
    logic             w_carry;
    logic [WIDTH-1:0] w_r;
    logic             w_ovf;
    logic             w_ge;

    // Multiply step: a wrapped add means the carry-out of HI + M was set.
    assign w_sum   = r_lo[0] ? i_alu_result : r_hi;
    assign w_carry = r_lo[0] & (i_alu_result < r_hi);

    assign w_r   = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
    assign w_ovf = r_hi[WIDTH-1];
    assign w_ge  = w_ovf | (w_r >= r_m);

    assign bus.busy = (r_state != IDLE);
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

    always_comb begin
        o_alu_src_a   = '0;
        o_alu_src_b   = '0;
        o_alu_control = ALU_ADD;
        unique case (r_state)
            MUL: begin
                o_alu_src_a   = r_hi;
                o_alu_src_b   = r_m;
                o_alu_control = ALU_ADD;
            end
            DIV: begin
                o_alu_src_a   = w_r;
                o_alu_src_b   = r_m;
                o_alu_control = ALU_SUB;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_m     <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_hi  <= '0;
                        r_cnt <= '0;
                        if (bus.op_div) begin
                            r_lo    <= bus.src_a;
                            r_m     <= bus.src_b;
                            r_state <= DIV;
                        end else begin
                            r_lo    <= bus.src_b;
                            r_m     <= bus.src_a;
                            r_state <= MUL;
                        end
                    end else if (bus.mthi) begin
                        r_hi <= bus.wdata;
                    end else if (bus.mtlo) begin
                        r_lo <= bus.wdata;
                    end
                end
                MUL: begin
                    {r_hi, r_lo} <= {w_carry, w_sum, r_lo[WIDTH-1:1]};
                    if (r_cnt == LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DIV: begin
                    r_hi <= w_ge ? i_alu_result : w_r;
                    r_lo <= {r_lo[WIDTH-2:0], w_ge};
                    if (r_cnt == LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_iter_ctrl.md
Name: alu_iter_ctrl

Overview:
- Multi-cycle controller that runs unsigned 32-bit multiply (MULTU) and divide (DIVU) as 32 shift/add iterations on the shared ALU.
- Drives the ALU operand and control inputs, consumes its result, and owns the HI/LO register pair.
- Sits beside the single-cycle datapath; the main controller issues start/mthi/mtlo and stalls on busy.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  launch operation; sampled only when idle
- op_div  in  1  0 = MULTU, 1 = DIVU; sampled with start
- src_a  in  WIDTH  multiplicand / dividend
- src_b  in  WIDTH  multiplier / divisor
- mthi  in  1  write wdata to HI when idle
- mtlo  in  1  write wdata to LO when idle
- wdata  in  WIDTH  data for mthi/mtlo
- alu_result  in  WIDTH  ALU output (ALUResult)
- alu_src_a  out  WIDTH  to ALU SrcA
- alu_src_b  out  WIDTH  to ALU SrcB
- alu_control  out  3  to ALU ALUControl: 3'b000 add, 3'b001 sub
- busy  out  1  operation in progress
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset:
  - state = IDLE, cnt = 0, HI = LO = 0, operand register M = 0, busy = 0.
  - Reset in the middle of an operation aborts it identically.
- States: IDLE, MUL, DIV. busy = (state != IDLE), decoded from the registered state.
- IDLE priority in one cycle: start > mthi > mtlo. Only the highest-priority request is honoured; the others are dropped.
- While busy, start, mthi and mtlo are ignored. The caller must hold them until busy is 0.
- Start with op_div = 0:
  - LO <= src_b, HI <= 0, M <= src_a, cnt <= 0, go to MUL.
- Start with op_div = 1:
  - LO <= src_a (quotient/dividend), HI <= 0 (remainder), M <= src_b (divisor), go to DIV.
- MUL iteration, one per cycle:
  - Drive alu_src_a = HI, alu_src_b = M, alu_control = 000.
  - sum = LO[0] ? alu_result : HI.
  - carry = LO[0] & (alu_result < HI), unsigned compare.
  - {HI, LO} <= {carry, sum, LO} >> 1.
- DIV iteration, one per cycle (restoring division):
  - r = {HI[WIDTH-2:0], LO[WIDTH-1]}, ovf = HI[WIDTH-1].
  - Drive alu_src_a = r, alu_src_b = M, alu_control = 001.
  - ge = ovf | (r >= M), unsigned compare.
  - HI <= ge ? alu_result : r; LO <= {LO[WIDTH-2:0], ge}.
  - The 32-bit wrap of the ALU subtraction is correct when ovf = 1.
- Counter:
  - cnt increments each iteration.
  - On the edge where cnt == WIDTH-1: last iteration commits, state <= IDLE, cnt <= 0.
  - busy is high for exactly WIDTH (32) cycles, starting the cycle after the start edge.
  - Result is valid in the first cycle busy = 0.
- In IDLE the ALU outputs are alu_src_a = alu_src_b = 0, alu_control = 000.
- During busy, hi/lo show intermediate values; the consumer must not use them.
- Divide by zero: no trap, full 32 cycles, LO = all ones, HI = dividend.
- Back-to-back: start is accepted in the first idle cycle after completion.

Decomposition:
- Shared package (used with the ALU decoder):
  - ALU opcode constants ALU_ADD = 3'b000, ALU_SUB = 3'b001.
  - State encodings IDLE/MUL/DIV.
- No sub-module: ALU instantiated by the parent; counter and FSM kept inline.

Test Plan:
- reset; start MULTU a=3, b=5 -> busy high exactly 32 cycles; then hi=0x00000000, lo=0x0000000F.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 (exercises the carry path).
- DIVU 100/7 -> lo=14, hi=2; DIVU 0xFFFFFFFF/0x80000001 -> lo=1, hi=0x7FFFFFFE (exercises ovf).
- DIVU 0x1234/0 -> after 32 cycles lo=0xFFFFFFFF, hi=0x00001234.
- During busy, pulse start, mthi, mtlo with wdata=0xAAAA -> ignored, result unchanged.
  - In idle, assert start + mthi together -> only start taken.
  - mtlo alone -> lo=0xAAAA next cycle.
- Reset asserted at iteration 10 of a MULTU -> next cycle busy=0, hi=lo=0, and a new start works normally.
